// File: rtl/avalon_snapshot_in_pio_pkg.sv
// Shared register map, bit positions and channel-slice helper for the snapshot input PIO.
package avalon_pio_pkg;

  localparam int CTRL_OFS     = 0;
  localparam int STATUS_OFS   = 1;
  localparam int IRQ_MASK_OFS = 2;
  localparam int CH_COUNT_OFS = 3;
  localparam int CH_BASE      = 4;

  localparam int MODE_BIT    = 0;
  localparam int SW_SNAP_BIT = 1;
  localparam int NEW_BIT     = 0;
  localparam int OVR_BIT     = 1;

  // Widest possible packed input: 12 channels of 32 bits.
  localparam int MAX_BUS_W = 12 * 32;

  function automatic logic [31:0] channel_of(input logic [MAX_BUS_W-1:0] bus,
                                             input int k, input int dw);
    logic [MAX_BUS_W-1:0] sh;
    logic [31:0]          m;
    sh = bus >> (k * dw);
    m  = (dw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << dw) - 32'd1);
    return sh[31:0] & m;
  endfunction

endpackage

// File: rtl/avalon_snapshot_in_pio_if.sv
// Avalon-MM slave bus bundle: master drives address/strobes/writedata, slave returns readdata.
interface avalon_snapshot_in_pio_if #(parameter int ADDR_W = 4);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [31:0]       readdata;

  modport master (output address, read, write, writedata, input readdata);
  modport slave  (input address, read, write, writedata, output readdata);
endinterface

// File: rtl/avalon_snapshot_in_pio_snapshot_bank.sv
// NUM_CH x DATA_W shadow registers loaded together on one enable, with a combinational read mux.
module pio_snapshot_bank #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 20,
  parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     load,
  input  logic [NUM_CH*DATA_W-1:0] in_port,
  input  logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] shadow [NUM_CH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_CH; k++) shadow[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < NUM_CH; k++) shadow[k] <= in_port[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(sel) == k) rd_data = shadow[k];
    end
  end

endmodule

// File: rtl/avalon_snapshot_in_pio.sv
// Multi-channel Avalon-MM input PIO: live or coherent-snapshot channel reads, NEW/OVR flags, masked irq.
// Read latency 1 (readdata registered); no wait states.
module avalon_snapshot_in_pio
  import avalon_pio_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 20,
  parameter int ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  avalon_snapshot_in_pio_if.slave  bus,
  input  logic [NUM_CH*DATA_W-1:0] in_port,
  input  logic                     sample_stb,
  output logic                     irq
);

  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic        mode;
  logic        new_f;
  logic        ovr_f;
  logic [1:0]  irq_mask;
  logic [31:0] rd_q;
  logic [31:0] rd_mux;

  logic              wr_ctrl, wr_status, wr_mask;
  logic              is_ch, is_last;
  logic              capture, rd_last;
  logic [ADDR_W-1:0] ch_off;
  logic [DATA_W-1:0] shadow_rd;
  logic [MAX_BUS_W-1:0] in_ext;
  logic              unused_ok;

  assign wr_ctrl   = bus.write && (int'(bus.address) == CTRL_OFS);
  assign wr_status = bus.write && (int'(bus.address) == STATUS_OFS);
  assign wr_mask   = bus.write && (int'(bus.address) == IRQ_MASK_OFS);

  assign ch_off  = bus.address - ADDR_W'(CH_BASE);
  assign is_ch   = (int'(bus.address) >= CH_BASE) && (int'(bus.address) < CH_BASE + NUM_CH);
  assign is_last = int'(bus.address) == CH_BASE + NUM_CH - 1;

  // Captures and the last-channel auto-clear only exist in snapshot mode.
  assign capture = mode && (sample_stb || (wr_ctrl && bus.writedata[SW_SNAP_BIT]));
  assign rd_last = mode && bus.read && is_last;

  assign in_ext    = MAX_BUS_W'(in_port);
  assign unused_ok = &{1'b0, bus.writedata[31:2]};

  pio_snapshot_bank #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .SEL_W(SEL_W)) u_bank (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (capture),
    .in_port (in_port),
    .sel     (SEL_W'(ch_off)),
    .rd_data (shadow_rd)
  );

  always_comb begin
    rd_mux = '0;
    if (int'(bus.address) == CTRL_OFS) begin
      rd_mux[MODE_BIT] = mode;
    end else if (int'(bus.address) == STATUS_OFS) begin
      rd_mux[NEW_BIT] = new_f;
      rd_mux[OVR_BIT] = ovr_f;
    end else if (int'(bus.address) == IRQ_MASK_OFS) begin
      rd_mux[1:0] = irq_mask;
    end else if (int'(bus.address) == CH_COUNT_OFS) begin
      rd_mux = 32'(NUM_CH);
    end else if (is_ch) begin
      rd_mux = mode ? 32'(shadow_rd) : channel_of(in_ext, int'(ch_off), DATA_W);
    end
  end

  // Setting a flag always beats clearing it in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode     <= 1'b0;
      irq_mask <= 2'b00;
      new_f    <= 1'b0;
      ovr_f    <= 1'b0;
      rd_q     <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_ctrl) mode     <= bus.writedata[MODE_BIT];
      if (wr_mask) irq_mask <= bus.writedata[1:0];

      if (capture)
        new_f <= 1'b1;
      else if (rd_last || (wr_status && bus.writedata[NEW_BIT]))
        new_f <= 1'b0;

      if (capture && new_f)
        ovr_f <= 1'b1;
      else if (wr_status && bus.writedata[OVR_BIT])
        ovr_f <= 1'b0;

      if (bus.read) rd_q <= rd_mux;
      irq <= |({ovr_f, new_f} & irq_mask);
    end
  end

  assign bus.readdata = rd_q;

endmodule
